// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and arrow/Enter key-state decoder for the race game input stage.
// Latency: scan_code/scan_valid 1 clk after the filtered stop-bit fall; key levels and key_release 1 clk after scan_valid.
// Backpressure: none; every accepted byte is presented for exactly one cycle and the consumer must take it.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       left_key,
    output logic       right_key,
    output logic       enter_key,
    output logic       key_release,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    // Receive FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Scan codes the decoder cares about
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    // Watchdog sizing: counts up to TIMEOUT_CYCLES-1, then fires
    localparam int               WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES - 1);

    // Synchronizer stages (lines idle high, so reset to 1)
    logic r_ps2c_s1;
    logic r_ps2c_s2;
    logic r_ps2d_s1;
    logic r_ps2d_s2;

    // Clock glitch filter
    logic [FILTER_LEN-1:0] r_filt_sr;
    logic                  r_filt;
    logic                  r_filt_q;
    logic                  w_fall;

    // Receive path
    logic [1:0]        r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [WDOG_W-1:0] r_wdog;
    logic              w_timeout;
    logic              w_frame_ok;

    // Byte output
    logic [7:0] r_scan_code;
    logic       r_scan_valid;
    logic       r_frame_err;

    // Decoder state
    logic r_ext;
    logic r_brk;
    logic r_left;
    logic r_right;
    logic r_enter;
    logic r_key_release;
    logic w_is_left;
    logic w_is_right;
    logic w_is_enter;

    // Two-flop synchronizers for both asynchronous PS/2 lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ps2c_s1 <= 1'b1;
            r_ps2c_s2 <= 1'b1;
            r_ps2d_s1 <= 1'b1;
            r_ps2d_s2 <= 1'b1;
        end else begin
            r_ps2c_s1 <= ps2c;
            r_ps2c_s2 <= r_ps2c_s1;
            r_ps2d_s1 <= ps2d;
            r_ps2d_s2 <= r_ps2d_s1;
        end
    end

    // Filtered clock only moves after FILTER_LEN agreeing samples; otherwise it holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt_sr <= '1;
            r_filt    <= 1'b1;
            r_filt_q  <= 1'b1;
        end else begin
            r_filt_sr <= {r_filt_sr[FILTER_LEN-2:0], r_ps2c_s2};
            r_filt_q  <= r_filt;
            if (&r_filt_sr) begin
                r_filt <= 1'b1;
            end else if (~|r_filt_sr) begin
                r_filt <= 1'b0;
            end
        end
    end

    // A fall is a 1->0 transition of the filtered clock; data is sampled then
    assign w_fall     = r_filt_q & ~r_filt;
    assign w_timeout  = (r_state != ST_IDLE) && !w_fall && (r_wdog == WDOG_MAX);
    // Odd parity: data bits plus parity bit must contain an odd number of ones
    assign w_frame_ok = r_ps2d_s2 && (^{r_shift, r_parity});

    // Frame receive FSM with watchdog; emits accepted bytes and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_wdog       <= '0;
            r_scan_code  <= 8'h00;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            // Watchdog runs only mid-frame and restarts on every clock fall
            if (w_fall || (r_state == ST_IDLE) || w_timeout) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            if (w_timeout) begin
                // Stalled frame: drop the partial byte and resynchronise on the next start bit
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_ps2d_s2) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_shift <= {r_ps2d_s2, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        r_parity <= r_ps2d_s2;
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_frame_ok) begin
                            r_scan_code  <= r_shift;
                            r_scan_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Key identity of the current final code, qualified by the extended prefix
    assign w_is_left  = r_ext  && (r_scan_code == CODE_LEFT);
    assign w_is_right = r_ext  && (r_scan_code == CODE_RIGHT);
    assign w_is_enter = !r_ext && (r_scan_code == CODE_ENTER);

    // Make/break decoder: prefixes set flags, final codes update levels and clear flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_enter       <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_key_release <= 1'b0;
            if (r_scan_valid) begin
                if (r_scan_code == CODE_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_scan_code == CODE_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    // Release strobes for any key, matched or not
                    if (r_brk) begin
                        r_key_release <= 1'b1;
                    end
                    if (w_is_left) begin
                        r_left <= !r_brk;
                    end
                    if (w_is_right) begin
                        r_right <= !r_brk;
                    end
                    if (w_is_enter) begin
                        r_enter <= !r_brk;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign left_key    = r_left;
    assign right_key   = r_right;
    assign enter_key   = r_enter;
    assign key_release = r_key_release;
    assign scan_code   = r_scan_code;
    assign scan_valid  = r_scan_valid;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of frames plus hand-written corner sequences.
// PS/2 clock is scaled down (HP clk cycles per half period) and the watchdog shortened.
// Outputs are sampled on the falling clk edge.
module tb_ps2_key_decoder;

    localparam int HP      = 20;
    localparam int SETTLE  = 40;
    localparam int TIMEOUT = 600;

    logic       clk;
    logic       reset;
    logic       ps2d;
    logic       ps2c;
    logic       left_key;
    logic       right_key;
    logic       enter_key;
    logic       key_release;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_key_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2d        (ps2d),
        .ps2c        (ps2c),
        .left_key    (left_key),
        .right_key   (right_key),
        .enter_key   (enter_key),
        .key_release (key_release),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Pulse-cycle totals and event timestamps, sampled on the falling edge
    int cyc          = 0;
    int sv_tot       = 0;
    int rel_tot      = 0;
    int err_tot      = 0;
    int last_sv_cyc  = 0;
    int left_up_cyc  = 0;
    int rel_cyc      = 0;
    logic left_q     = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        left_q <= left_key;
        if (scan_valid)  begin sv_tot  <= sv_tot + 1;  last_sv_cyc <= cyc; end
        if (key_release) begin rel_tot <= rel_tot + 1; rel_cyc <= cyc; end
        if (frame_err)   err_tot <= err_tot + 1;
        if (left_key && !left_q) left_up_cyc <= cyc;
    end

    typedef struct {
        logic [7:0] dat;
        bit         bad;
        int         sv;
        logic [7:0] code;
        bit         l;
        bit         r;
        bit         e;
        int         rel;
        int         err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input bit bad, input int sv,
                                input logic [7:0] code, input bit l, input bit r,
                                input bit e, input int rel, input int err);
        vec_t v;
        v.dat = d; v.bad = bad; v.sv = sv; v.code = code;
        v.l = l; v.r = r; v.e = e; v.rel = rel; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first n bits of an 11-bit frame (bit 0 = start bit)
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2d = bits[i];
            wait_cyc(HP);
            ps2c = 1'b0;
            wait_cyc(HP);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad);
        logic par;
        par = (~^d) ^ bad;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bad);
        send_bits(frame_bits(d, bad), 11);
        wait_cyc(SETTLE);
    endtask

    task automatic chk_levels(input string tag, input bit l, input bit r, input bit e);
        chk({tag, " left_key"},  int'(left_key),  int'(l));
        chk({tag, " right_key"}, int'(right_key), int'(r));
        chk({tag, " enter_key"}, int'(enter_key), int'(e));
    endtask

    initial begin
        int sv0, rel0, err0;
        logic [10:0] fb;

        ps2c  = 1'b1;
        ps2d  = 1'b1;
        reset = 1'b1;

        tbl.push_back(mk(8'h1C, 0, 1, 8'h1C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(8'hE0, 0, 1, 8'hE0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(8'h6B, 0, 1, 8'h6B, 1, 0, 0, 0, 0));
        tbl.push_back(mk(8'hE0, 0, 1, 8'hE0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(8'hF0, 0, 1, 8'hF0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(8'h6B, 0, 1, 8'h6B, 0, 0, 0, 1, 0));
        tbl.push_back(mk(8'h6B, 0, 1, 8'h6B, 0, 0, 0, 0, 0));   // keypad 4, no E0
        tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 1, 0, 0)); // typematic repeats
        tbl.push_back(mk(8'hF0, 0, 1, 8'hF0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 0, 1, 0));
        tbl.push_back(mk(8'h5A, 1, 0, 8'h5A, 0, 0, 0, 0, 1));   // bad parity
        tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 1, 0, 0));
        tbl.push_back(mk(8'hF0, 1, 0, 8'h5A, 0, 0, 1, 0, 1));   // bad break prefix
        tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 1, 0, 0));   // still a make
        tbl.push_back(mk(8'hF0, 0, 1, 8'hF0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(8'h5A, 0, 1, 8'h5A, 0, 0, 0, 1, 0));

        // Reset state
        wait_cyc(5);
        chk("reset scan_code", int'(scan_code), 0);
        chk_levels("reset", 0, 0, 0);
        chk("reset scan_valid", int'(scan_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset key_release", int'(key_release), 0);
        reset = 1'b0;
        wait_cyc(20);
        chk("idle no pulses", sv_tot + rel_tot + err_tot, 0);

        // Table-driven frames
        foreach (tbl[k]) begin
            string tag;
            tag = $sformatf("vec%0d(%02h%s)", k, tbl[k].dat, tbl[k].bad ? "/bad" : "");
            sv0 = sv_tot; rel0 = rel_tot; err0 = err_tot;
            send_frame(tbl[k].dat, tbl[k].bad);
            chk({tag, " scan_valid"}, sv_tot - sv0, tbl[k].sv);
            chk({tag, " scan_code"}, int'(scan_code), int'(tbl[k].code));
            chk_levels(tag, tbl[k].l, tbl[k].r, tbl[k].e);
            chk({tag, " key_release"}, rel_tot - rel0, tbl[k].rel);
            chk({tag, " frame_err"}, err_tot - err0, tbl[k].err);
        end

        // Make latency: left_key rises exactly 1 clk after the 6B scan_valid
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        chk("left rise latency", left_up_cyc - last_sv_cyc, 1);
        chk("left held", int'(left_key), 1);

        // Break latency and pulse width
        rel0 = rel_tot;
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h6B, 0);
        chk("left break level", int'(left_key), 0);
        chk("left break release width", rel_tot - rel0, 1);
        chk("release latency", rel_cyc - last_sv_cyc, 1);

        // Start bit high is a framing error
        sv0 = sv_tot; err0 = err_tot;
        send_bits(11'h7FF, 1);
        wait_cyc(SETTLE);
        chk("start-bit err", err_tot - err0, 1);
        chk("start-bit no valid", sv_tot - sv0, 0);

        // Watchdog: start bit plus 4 data bits, then the clock stalls high
        sv0 = sv_tot; err0 = err_tot;
        send_bits(frame_bits(8'h74, 0), 5);
        wait_cyc(TIMEOUT / 2);
        chk("no early timeout", err_tot - err0, 0);
        wait_cyc(TIMEOUT);
        chk("timeout err", err_tot - err0, 1);
        chk("timeout no valid", sv_tot - sv0, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h74, 0);
        chk("after timeout scan_code", int'(scan_code), 8'h74);
        chk_levels("after timeout", 0, 1, 0);

        // Simultaneous arrows, then reset in the middle of a frame
        send_frame(8'hE0, 0);
        send_frame(8'h6B, 0);
        chk_levels("both arrows", 1, 1, 0);
        fb = frame_bits(8'h5A, 0);
        send_bits(fb, 4);
        #2 reset = 1'b1;
        #1;
        chk_levels("mid-frame reset", 0, 0, 0);
        chk("mid-frame reset scan_code", int'(scan_code), 0);
        wait_cyc(10);
        reset = 1'b0;
        wait_cyc(10);
        sv0 = sv_tot;
        send_frame(8'h5A, 0);
        chk("post-reset valid", sv_tot - sv0, 1);
        chk("post-reset scan_code", int'(scan_code), 8'h5A);
        chk_levels("post-reset", 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
